// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with a handshaked memory port.
// Optional: define MIPS_MC_ILLEGAL_TRAP_EN to send illegal opcodes to TRAP (default: illegal op is a NOP).
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       bne,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       extend,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] memwrite,
  output logic [1:0] ls_size,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // The request may be held for MEM_TIMEOUT cycles; the last of them is still allowed to complete.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  state_t           cur_state, nxt_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [5:0]       op_q;
  logic             running;
  logic             err_q;
  logic             timeout;

  // running stays low from reset until the first clock edge after release, holding all outputs idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= FETCH;
      wait_cnt  <= '0;
      op_q      <= '0;
      running   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      running   <= 1'b1;
      cur_state <= nxt_state;
      if (nxt_state != cur_state)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (cur_state == DECODE)
        op_q <= op;
      if (timeout)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    timeout   = 1'b0;
    mem_req   = 1'b0;
    iord      = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    bne       = 1'b0;
    pcsrc     = 2'b00;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    extend    = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 2'b00;
    ls_size   = 2'b00;
    if (running) begin
      case (cur_state)
        FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          if (mem_ready) begin
            irwrite   = 1'b1;
            pcwrite   = 1'b1;
            nxt_state = DECODE;
          end else if (wait_cnt == LAST_WAIT) begin
            timeout   = 1'b1;
            nxt_state = TRAP;
          end
        end
        DECODE: begin
          alusrcb = 2'b11;
          case (op)
            OP_RTYPE:                                   nxt_state = RTEX;
            OP_LW, OP_LH, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB: nxt_state = MEMADR;
            OP_BEQ, OP_BNE:                             nxt_state = BRANCH;
            OP_ADDI, OP_ORI:                            nxt_state = IMMEX;
            OP_J:                                       nxt_state = JUMP;
            default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
              nxt_state = TRAP;
`else
              nxt_state = FETCH;
`endif
            end
          endcase
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          extend  = 1'b1;
          case (op_q)
            OP_LW, OP_LH, OP_LB, OP_LBU: nxt_state = MEMRD;
            OP_SW, OP_SH, OP_SB:         nxt_state = MEMWR;
            default:                     nxt_state = FETCH;
          endcase
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          case (op_q)
            OP_LH:   ls_size = 2'b01;
            OP_LB:   ls_size = 2'b10;
            OP_LBU:  ls_size = 2'b11;
            default: ls_size = 2'b00;
          endcase
          if (mem_ready) begin
            nxt_state = MEMWB;
          end else if (wait_cnt == LAST_WAIT) begin
            timeout   = 1'b1;
            nxt_state = TRAP;
          end
        end
        MEMWB: begin
          regwrite  = 1'b1;
          memtoreg  = 1'b1;
          nxt_state = FETCH;
        end
        MEMWR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          case (op_q)
            OP_SW:   memwrite = 2'b01;
            OP_SH:   memwrite = 2'b10;
            OP_SB:   memwrite = 2'b11;
            default: memwrite = 2'b00;
          endcase
          if (mem_ready) begin
            nxt_state = FETCH;
          end else if (wait_cnt == LAST_WAIT) begin
            timeout   = 1'b1;
            nxt_state = TRAP;
          end
        end
        RTEX: begin
          alusrca   = 1'b1;
          aluop     = 2'b11;
          nxt_state = ALUWB;
        end
        ALUWB: begin
          regwrite  = 1'b1;
          regdst    = 1'b1;
          nxt_state = FETCH;
        end
        BRANCH: begin
          alusrca   = 1'b1;
          aluop     = 2'b01;
          pcsrc     = 2'b01;
          branch    = (op_q == OP_BEQ);
          bne       = (op_q == OP_BNE);
          nxt_state = FETCH;
        end
        IMMEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          if (op_q == OP_ORI)
            aluop = 2'b10;
          else
            extend = 1'b1;
          nxt_state = IMMWB;
        end
        IMMWB: begin
          regwrite  = 1'b1;
          nxt_state = FETCH;
        end
        JUMP: begin
          pcwrite   = 1'b1;
          pcsrc     = 2'b10;
          nxt_state = FETCH;
        end
        TRAP:    nxt_state = TRAP;
        default: nxt_state = FETCH;
      endcase
    end
  end

  assign bus_err = err_q;
  assign state   = cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, hand-written timeout/reset sequences, and random instruction streams.
module tb_mips_multicycle_ctrl;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       mem_req, iord, irwrite, pcwrite, branch, bne, alusrca, extend, regdst, memtoreg, regwrite, bus_err;
  logic [1:0] pcsrc, alusrcb, aluop, memwrite, ls_size;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  logic trapped = 1'b0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .bne(bne), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .extend(extend), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .memwrite(memwrite), .ls_size(ls_size), .bus_err(bus_err),
    .state(state)
  );

  wire [21:0] outv = {mem_req, iord, irwrite, pcwrite, branch, bne, pcsrc, alusrca, alusrcb,
                      aluop, extend, regdst, memtoreg, regwrite, memwrite, ls_size, bus_err};

  typedef struct {
    logic [5:0] op; logic rdy; logic [3:0] st;
    logic req; logic irw; logic pcw; logic rw; logic mtr; logic rd;
    logic [1:0] aluop; logic [1:0] pcsrc; logic ext; logic br; logic bn;
    logic [1:0] lss; logic [1:0] mw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected output vector for one cycle, derived from the state meanings of the control unit.
  function automatic logic [21:0] expv(input int st, input logic [5:0] o, input logic rdy, input logic be);
    logic req = 0, io = 0, irw = 0, pcw = 0, br = 0, bn = 0, asa = 0, ext = 0, rd = 0, mtr = 0, rw = 0;
    logic [1:0] pcs = 0, asb = 0, aop = 0, mw = 0, lss = 0;
    case (st)
      0:  begin req = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; ext = 1; end
      3:  begin req = 1; io = 1; lss = (o == 6'h23) ? 2'd0 : (o == 6'h21) ? 2'd1 : (o == 6'h20) ? 2'd2 : 2'd3; end
      4:  begin rw = 1; mtr = 1; end
      5:  begin req = 1; io = 1; mw = (o == 6'h2b) ? 2'd1 : (o == 6'h29) ? 2'd2 : 2'd3; end
      6:  begin asa = 1; aop = 2'd3; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'd1; pcs = 2'd1; br = (o == 6'h04); bn = (o == 6'h05); end
      9:  begin asa = 1; asb = 2'd2; if (o == 6'h0d) aop = 2'd2; else ext = 1; end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'd2; end
      default: ;
    endcase
    return {req, io, irw, pcw, br, bn, pcs, asa, asb, aop, ext, rd, mtr, rw, mw, lss, be};
  endfunction

  // 0 R-type, 1 load, 2 store, 3 branch, 4 immediate, 5 jump, 6 illegal
  function automatic int op_class(input logic [5:0] o);
    case (o)
      6'h00: return 0;
      6'h23, 6'h21, 6'h20, 6'h24: return 1;
      6'h2b, 6'h29, 6'h28: return 2;
      6'h04, 6'h05: return 3;
      6'h08, 6'h0d: return 4;
      6'h02: return 5;
      default: return 6;
    endcase
  endfunction

  task automatic step(input logic [5:0] o, input logic rdy, input int st, input logic [21:0] ev);
    op = o;
    mem_ready = rdy;
    @(negedge clk);
    chk($sformatf("cyc_st%0d", st), {6'd0, state, outv}, {6'd0, 4'(st), ev});
    @(posedge clk);
    #1;
  endtask

  // One memory-handshake state: d idle cycles then ready, or a timeout when d >= T.
  task automatic mem_phase(input int st, input logic [5:0] o, input int d, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < T; i++) begin
      logic r;
      r = (i == d);
      step(6'($urandom), r, st, expv(st, o, r, 1'b0));
      if (r) begin
        ok = 1'b1;
        return;
      end
    end
    step(6'($urandom), 1'b1, 15, expv(15, o, 1'b0, 1'b1));
    trapped = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] o, input int df, input int dm);
    logic ok;
    mem_phase(0, o, df, ok);
    if (!ok) return;
    step(o, 1'($urandom), 1, expv(1, o, 1'b0, 1'b0));
    case (op_class(o))
      0: begin
        step(6'($urandom), 1'($urandom), 6, expv(6, o, 1'b0, 1'b0));
        step(6'($urandom), 1'($urandom), 7, expv(7, o, 1'b0, 1'b0));
      end
      1: begin
        step(6'($urandom), 1'($urandom), 2, expv(2, o, 1'b0, 1'b0));
        mem_phase(3, o, dm, ok);
        if (ok) step(6'($urandom), 1'($urandom), 4, expv(4, o, 1'b0, 1'b0));
      end
      2: begin
        step(6'($urandom), 1'($urandom), 2, expv(2, o, 1'b0, 1'b0));
        mem_phase(5, o, dm, ok);
      end
      3: step(6'($urandom), 1'($urandom), 8, expv(8, o, 1'b0, 1'b0));
      4: begin
        step(6'($urandom), 1'($urandom), 9, expv(9, o, 1'b0, 1'b0));
        step(6'($urandom), 1'($urandom), 10, expv(10, o, 1'b0, 1'b0));
      end
      5: step(6'($urandom), 1'($urandom), 11, expv(11, o, 1'b0, 1'b0));
      default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        step(6'($urandom), 1'($urandom), 15, expv(15, o, 1'b0, 1'b0));
        trapped = 1'b1;
`endif
      end
    endcase
  endtask

  // Called #1 after a rising edge; asserts reset mid-cycle and releases it before the next edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_async", {6'd0, state, outv}, 32'd0);
    #2;
    reset_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_idle", {6'd0, state, outv}, 32'd0);
    @(posedge clk);
    #1;
    trapped = 1'b0;
  endtask

  vec_t vt[23];
  logic [5:0] legal_ops[13] = '{6'h00, 6'h23, 6'h21, 6'h20, 6'h24, 6'h2b, 6'h29, 6'h28,
                                6'h04, 6'h05, 6'h08, 6'h0d, 6'h02};

  initial begin
    //        op     rdy st  req irw pcw rw mtr rd aluop pcsrc ext br bn lss mw
    vt[0]  = '{6'h3f, 1, 0,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{6'h23, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{6'h3f, 0, 2,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vt[3]  = '{6'h3f, 1, 3,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{6'h3f, 0, 4,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[5]  = '{6'h00, 1, 0,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{6'h05, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{6'h3f, 0, 8,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    vt[8]  = '{6'h00, 1, 0,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{6'h0d, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[10] = '{6'h3f, 0, 9,  0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    vt[11] = '{6'h3f, 0, 10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[12] = '{6'h00, 1, 0,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[13] = '{6'h28, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[14] = '{6'h3f, 0, 2,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vt[15] = '{6'h3f, 0, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    vt[16] = '{6'h3f, 0, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    vt[17] = '{6'h3f, 0, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    vt[18] = '{6'h3f, 1, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    vt[19] = '{6'h3f, 1, 0,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[20] = '{6'h00, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[21] = '{6'h3f, 0, 6,  0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0};
    vt[22] = '{6'h3f, 0, 7,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    @(posedge clk);
    #1;
    do_reset();

    // lw, bne, ori, sb (ready on the last allowed wait cycle), R-type
    for (int i = 0; i < 23; i++) begin
      op = vt[i].op;
      mem_ready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {11'd0, state, mem_req, irwrite, pcwrite, regwrite, memtoreg, regdst, aluop, pcsrc, extend, branch, bne, ls_size, memwrite},
          {11'd0, vt[i].st, vt[i].req, vt[i].irw, vt[i].pcw, vt[i].rw, vt[i].mtr, vt[i].rd, vt[i].aluop, vt[i].pcsrc,
           vt[i].ext, vt[i].br, vt[i].bn, vt[i].lss, vt[i].mw});
      @(posedge clk);
      #1;
    end
    chk("bus_err_after_table", {31'd0, bus_err}, 32'd0);

    // Fetch timeout: four unanswered request cycles, then TRAP held until reset
    run_instr(6'h23, T, 0);
    chk("fetch_trapped", {31'd0, trapped}, 32'd1);
    step(6'h00, 1'b1, 15, expv(15, 6'h00, 1'b0, 1'b1));
    step(6'h23, 1'b0, 15, expv(15, 6'h00, 1'b0, 1'b1));
    do_reset();

    // Store timeout in MEMWR
    run_instr(6'h2b, 0, T);
    chk("store_trapped", {31'd0, trapped}, 32'd1);
    do_reset();

    // Illegal opcode, then a normal load to confirm the flow continues
    run_instr(6'h3f, 0, 0);
    if (trapped) do_reset();
    run_instr(6'h24, 1, 2);

    // Reset pulse while a store is waiting in MEMWR
    step(6'h00, 1'b1, 0, expv(0, 6'h00, 1'b1, 1'b0));
    step(6'h29, 1'b0, 1, expv(1, 6'h29, 1'b0, 1'b0));
    step(6'h00, 1'b0, 2, expv(2, 6'h29, 1'b0, 1'b0));
    step(6'h00, 1'b0, 5, expv(5, 6'h29, 1'b0, 1'b0));
    chk("memwr_active", {29'd0, mem_req, memwrite}, {29'd0, 1'b1, 2'b10});
    do_reset();
    chk("post_rst_state", {28'd0, state}, 32'd0);

    // Random instruction stream with random handshake delays inside the timeout window
    for (int n = 0; n < 200; n++) begin
      logic [5:0] o;
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      else o = legal_ops[$urandom_range(0, 12)];
      run_instr(o, $urandom_range(0, T - 1), $urandom_range(0, T - 1));
      if (trapped) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle successor to the single-cycle main decoder. It sequences one MIPS instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states. Each state drives datapath enables and muxes from an opcode latched at DECODE. Memory access uses a req/ready handshake with a programmable timeout. The block sits between the instruction register and the shared multicycle datapath and memory port.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before bus error (1..255)
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
op  in  6  opcode from instruction register; sampled only in DECODE
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request; held until mem_ready or timeout
iord  out  1  memory address source: 0 = PC, 1 = ALUOut
irwrite  out  1  load instruction register
pcwrite  out  1  unconditional PC update
branch  out  1  beq PC-update qualifier
bne  out  1  bne PC-update qualifier
pcsrc  out  2  00 ALU, 01 ALUOut, 10 jump target
alusrca  out  1  0 = PC, 1 = rs
alusrcb  out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2
aluop  out  2  00 add, 01 sub, 11 funct-decoded, 10 or
extend  out  1  1 = sign-extend imm, 0 = zero-extend
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  writeback from memory data
regwrite  out  1  register-file write strobe
memwrite  out  2  00 none, 01 word, 10 half, 11 byte
ls_size  out  2  load size: 00 word, 01 half, 10 byte, 11 byte unsigned
bus_err  out  1  sticky, set on memory timeout
state  out  4  current state encoding, for debug

Behaviour:
- States, with encodings:
  FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, TRAP=15.
- Reset (async, reset_n=0):
  - state=FETCH, timeout counter=0, latched op=0, bus_err=0.
  - All outputs are driven from the state, so pcwrite, irwrite, mem_req, regwrite and memwrite are 0 while reset_n=0. The first FETCH outputs appear after the first clk edge following deassertion.
- FETCH:
  - Drives mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - When mem_ready=1: irwrite=1 and pcwrite=1 in that cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Latches op. Drives alusrca=0, alusrcb=11, aluop=00 for the branch-target precompute.
  - Next state by op:
    - 000000 -> RTEX
    - 100011/100001/100000/100100/101011/101001/101000 -> MEMADR
    - 000100/000101 -> BRANCH
    - 001000 and 001101 -> IMMEX
    - 000010 -> JUMP
    - any other op -> illegal handling (see Optional Feature)
- MEMADR:
  - Drives alusrca=1, alusrcb=10, extend=1, aluop=00.
  - Loads go to MEMRD; stores go to MEMWR.
- MEMRD:
  - Drives mem_req=1, iord=1, and ls_size from the latched op (lw 00, lh 01, lb 10, lbu 11).
  - On mem_ready go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1; go to FETCH.
- MEMWR:
  - Drives mem_req=1, iord=1, and memwrite (sw 01, sh 10, sb 11).
  - memwrite is asserted only while mem_req=1. On mem_ready go to FETCH.
- RTEX: alusrca=1, alusrcb=00, aluop=11; go to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0; go to FETCH.
- BRANCH:
  - Drives alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - branch=1 for beq, bne=1 for bne. Exactly one of them is high.
  - Go to FETCH.
- IMMEX: alusrca=1, alusrcb=10; addi drives aluop=00, extend=1; ori drives aluop=10, extend=0. Go to IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0; go to FETCH.
- JUMP: pcwrite=1, pcsrc=10; go to FETCH.
- Timeout counter:
  - Clears on every state change. Increments each cycle that mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: set bus_err=1, drop mem_req, and go to TRAP without committing irwrite, pcwrite or memwrite.
  - If mem_ready=1 arrives in the same cycle the count reaches MEM_TIMEOUT, mem_ready wins: normal completion, no error.
- TRAP: all strobes 0, mem_req=0. Held until reset; bus_err stays 1.
- Any non-listed combination defaults every strobe to 0 and every mux select to 0. No X is driven on outputs.
- Reset asserted mid-access: mem_req drops asynchronously, and no write or regwrite completes.

Optional Feature:
- Macro: MIPS_MC_ILLEGAL_TRAP_EN.
- Defined: an illegal op in DECODE goes to TRAP. bus_err is unchanged; state reads 15.
- Undefined: an illegal op is treated as a NOP. DECODE goes straight to FETCH with no regwrite, memwrite or PC redirect beyond the PC+4 already committed in FETCH.

Test Plan:
- Reset, then lw (op 100011) with mem_ready=1 on the first request cycle -> state sequence 0,1,2,3,4,0; total 5 cycles; regwrite=1 and memtoreg=1 only in MEMWB; ls_size=00 in MEMRD.
- sb (101000) with mem_ready delayed 3 cycles in MEMWR -> memwrite=11 and mem_req=1 for exactly 4 cycles; then FETCH; bus_err=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> after 4 waiting cycles state=15, bus_err=1, irwrite and pcwrite never 1; reset_n low clears everything.
- bne (000101) then ori (001101) -> BRANCH shows bne=1, branch=0, aluop=01, pcsrc=01; IMMEX shows aluop=10, extend=0; IMMWB shows regwrite=1, regdst=0.
- Op 111111 -> with macro: state=15 after DECODE; without macro: DECODE -> FETCH with no write strobes.
- reset_n pulsed low during MEMWR with mem_req=1 -> mem_req and memwrite go to 0 without waiting for clk; state=0 afterwards.
